ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of register and ALU datapath.
REQ-002 Ports: one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 p3_pipeline_regWrite  in  1  enables the EX/MEM (p3) register update; 0 holds it.
REQ-004 EX_flush  in  1  replaces the next p3 contents with a bubble.
REQ-005 p2_alu_rm, p2_alu_rn, p2_alu_rd, p2_mem_rn, p2_mem_rd  in  3 each  register ids from ID.
REQ-006 p2_alu_reg_rm, p2_alu_reg_rn, p2_mem_reg_rn, p2_mem_reg_rd  in  DATA_W each  register values from ID.
REQ-007 p2_alu_imm, p2_memOffset  in  DATA_W  ALU immediate and memory offset.
REQ-008 p2_aluFunct  in  3  ALU function: ADD, SUB, AND, OR, XOR, SHL, SHR, CMP.
REQ-009 p2_aluSrcB, p2_alu_regWrite, p2_flag_regWrite, p2_memRead, p2_memWrite, p2_mem_regWrite  in  1 each  ID control signals.
REQ-010 p4_alu_regWrite, p4_mem_regWrite  in  1;  p4_alu_rd, p4_mem_rd  in  3;  p4_alu_aluOut, p4_mem_memOut  in  DATA_W  writeback results.
REQ-011 p3_alu_aluOut, p3_memAddr, p3_mem_storeData  out  DATA_W  registered EX results.
REQ-012 p3_alu_rd, p3_mem_rd  out  3;  p3_alu_regWrite, p3_mem_regWrite, p3_memRead, p3_memWrite, p3_flag_regWrite  out  1  registered controls.
REQ-013 p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v  out  1  registered flags (n, v feed ID branch logic).
REQ-014 EX_stall  out  1  load-use hazard; ID holds and EX inserts a bubble.

Function
REQ-015 Operand A = forwarded rn; operand B = forwarded rm when p2_aluSrcB=0, p2_alu_imm when 1.
REQ-016 ADD/SUB/CMP compute modulo 2^DATA_W; c = carry-out (SUB/CMP: c=1 when no borrow); v = signed overflow.
REQ-017 AND/OR/XOR: c=0, v=0; SHL/SHR shift by B[4:0], logical; c = last bit shifted out (0 for shift 0); v=0.
REQ-018 z = (result==0); n = result[DATA_W-1]; for all functions.
REQ-019 CMP forces p3_alu_regWrite=0 regardless of p2_alu_regWrite.
REQ-020 p3_memAddr = forwarded p2_mem_reg_rn + p2_memOffset, truncated to DATA_W; p3_mem_storeData = forwarded p2_mem_reg_rd.
REQ-021 Flags update only on p3 capture with p2_flag_regWrite=1; otherwise hold previous values.
REQ-022 Latency: one cycle, p2 inputs to p3 outputs.
REQ-023 Forwarding priority per source operand: p3 ALU result, then p4 ALU, then p4 mem, then p2 register value; p4_alu beats p4_mem on same rd.
REQ-024 Forwarding from p3 occurs only when p3_alu_regWrite=1 and rd matches; from p4 only when the matching regWrite=1.
REQ-025 EX_stall = p3_memRead AND p3_mem_regWrite AND p3_mem_rd equals any live p2 source id (alu rm if aluSrcB=0, alu rn, mem rn, mem rd if memWrite).
REQ-026 On EX_stall or EX_flush, p3 captures a bubble: all regWrite/memRead/memWrite/flag_regWrite=0, data fields 0, flags held.
REQ-027 p3_pipeline_regWrite=0 holds all p3 outputs and flags, overriding EX_flush and stall.
REQ-028 EX_stall deasserts the cycle after the bubble is inserted; a stall lasts exactly one cycle per hazard.

Reset
REQ-029 reset at a rising clk clears every p3 output and flag to 0; EX_stall is 0 while p3 is zeroed.
REQ-030 reset mid-stall overrides the stall and any pending flush.

Configuration
REQ-031 Macro EX_FORWARDING_EN defined: REQ-023/024/025 forwarding and stall logic present.
REQ-032 Macro absent: operands come directly from p2 register values; EX_stall is tied 0.

Structure
REQ-033 Shared package vliw_pkg holds the ALU function encodings, the flag struct, and the register-id width.
REQ-034 Combinational sub-module ex_alu computes result and flags; ex_stage holds forwarding, hazard, and p3 register.

Verification
REQ-035 ADD rn=0x7FFF_FFFF, rm=1 -> p3_alu_aluOut=0x8000_0000, n=1, v=1, z=0, c=0 one cycle later.
REQ-036 CMP rn=5, imm=5, aluSrcB=1 -> z=1, c=1, p3_alu_regWrite=0.
REQ-037 p3 ALU rd=2 writes 0x2222 while p4_alu rd=2 writes 0x1111; next instr reads r2 -> operand 0x2222.
REQ-038 Load to r3 in p3, then ADD reading r3 -> EX_stall=1 one cycle, bubble in p3, then correct forwarded result.
REQ-039 EX_flush=1 with p2_memWrite=1 -> p3_memWrite=0, flags unchanged; p3_pipeline_regWrite=0 -> outputs hold.
REQ-040 reset asserted during a stall -> all outputs 0 next edge; without EX_FORWARDING_EN, the REQ-037 scenario yields the stale p2 value.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared EX-stage types: ALU function codes, flag bundle, register-id width.
package vliw_pkg;

  localparam int REG_W = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_CMP = 3'd7
  } alu_fn_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU: result plus z/n/c/v flags for the EX stage.
module ex_alu
  import vliw_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        fn,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output flags_t            flags
);

  localparam int M = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;
  logic [DATA_W:0] shl;
  logic [DATA_W:0] shr;
  logic [4:0]      sh;
  logic            c;
  logic            v;

  assign sh  = b[4:0];
  assign sum = {1'b0, a} + {1'b0, b};
  // SUB as a + ~b + 1 so carry-out means "no borrow"
  assign dif = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
  assign shl = {1'b0, a} << sh;
  assign shr = {a, 1'b0} >> sh;

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    unique case (fn)
      ALU_ADD: begin
        result = sum[M:0];
        c      = sum[DATA_W];
        v      = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      ALU_SUB, ALU_CMP: begin
        result = dif[M:0];
        c      = dif[DATA_W];
        v      = (a[M] != b[M]) && (dif[M] != a[M]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: begin
        result = shl[M:0];
        c      = shl[DATA_W];
      end
      ALU_SHR: begin
        result = shr[DATA_W:1];
        c      = shr[0];
      end
    endcase
  end

  assign flags.z = ~|result;
  assign flags.n = result[M];
  assign flags.c = c;
  assign flags.v = v;

endmodule

// File: rtl/ex_stage.sv
// EX stage: operand forwarding, load-use stall, ALU and EX/MEM (p3) register.
// Define EX_FORWARDING_EN to enable forwarding and the load-use stall.
module ex_stage
  import vliw_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p3_pipeline_regWrite,
  input  logic              EX_flush,
  input  logic [REG_W-1:0]  p2_alu_rm,
  input  logic [REG_W-1:0]  p2_alu_rn,
  input  logic [REG_W-1:0]  p2_alu_rd,
  input  logic [REG_W-1:0]  p2_mem_rn,
  input  logic [REG_W-1:0]  p2_mem_rd,
  input  logic [DATA_W-1:0] p2_alu_reg_rm,
  input  logic [DATA_W-1:0] p2_alu_reg_rn,
  input  logic [DATA_W-1:0] p2_mem_reg_rn,
  input  logic [DATA_W-1:0] p2_mem_reg_rd,
  input  logic [DATA_W-1:0] p2_alu_imm,
  input  logic [DATA_W-1:0] p2_memOffset,
  input  logic [2:0]        p2_aluFunct,
  input  logic              p2_aluSrcB,
  input  logic              p2_alu_regWrite,
  input  logic              p2_flag_regWrite,
  input  logic              p2_memRead,
  input  logic              p2_memWrite,
  input  logic              p2_mem_regWrite,
  input  logic              p4_alu_regWrite,
  input  logic              p4_mem_regWrite,
  input  logic [REG_W-1:0]  p4_alu_rd,
  input  logic [REG_W-1:0]  p4_mem_rd,
  input  logic [DATA_W-1:0] p4_alu_aluOut,
  input  logic [DATA_W-1:0] p4_mem_memOut,
  output logic [DATA_W-1:0] p3_alu_aluOut,
  output logic [DATA_W-1:0] p3_memAddr,
  output logic [DATA_W-1:0] p3_mem_storeData,
  output logic [REG_W-1:0]  p3_alu_rd,
  output logic [REG_W-1:0]  p3_mem_rd,
  output logic              p3_alu_regWrite,
  output logic              p3_mem_regWrite,
  output logic              p3_memRead,
  output logic              p3_memWrite,
  output logic              p3_flag_regWrite,
  output logic              p3_flag_z,
  output logic              p3_flag_n,
  output logic              p3_flag_c,
  output logic              p3_flag_v,
  output logic              EX_stall
);

  logic [DATA_W-1:0] op_rn;
  logic [DATA_W-1:0] op_rm;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] mem_rn;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] alu_res;
  flags_t            alu_flags;
  flags_t            flags_q;

`ifdef EX_FORWARDING_EN
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_W-1:0]  id,
    input logic [DATA_W-1:0] val
  );
    if (p3_alu_regWrite && p3_alu_rd == id)
      return p3_alu_aluOut;
    else if (p4_alu_regWrite && p4_alu_rd == id)
      return p4_alu_aluOut;
    else if (p4_mem_regWrite && p4_mem_rd == id)
      return p4_mem_memOut;
    else
      return val;
  endfunction

  always_comb begin
    op_rn  = fwd(p2_alu_rn, p2_alu_reg_rn);
    op_rm  = fwd(p2_alu_rm, p2_alu_reg_rm);
    mem_rn = fwd(p2_mem_rn, p2_mem_reg_rn);
    mem_rd = fwd(p2_mem_rd, p2_mem_reg_rd);
  end

  // Loaded value is not available until p4, so a dependent op waits one cycle
  assign EX_stall = p3_memRead & p3_mem_regWrite & (
      (~p2_aluSrcB & (p3_mem_rd == p2_alu_rm))
    | (p3_mem_rd == p2_alu_rn)
    | (p3_mem_rd == p2_mem_rn)
    | (p2_memWrite & (p3_mem_rd == p2_mem_rd)));
`else
  logic unused_fwd;

  assign op_rn    = p2_alu_reg_rn;
  assign op_rm    = p2_alu_reg_rm;
  assign mem_rn   = p2_mem_reg_rn;
  assign mem_rd   = p2_mem_reg_rd;
  assign EX_stall = 1'b0;
  assign unused_fwd = ^{p2_alu_rm, p2_alu_rn, p2_mem_rn,
                        p4_alu_regWrite, p4_mem_regWrite,
                        p4_alu_rd, p4_mem_rd,
                        p4_alu_aluOut, p4_mem_memOut};
`endif

  assign op_b = p2_aluSrcB ? p2_alu_imm : op_rm;

  ex_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .fn     (p2_aluFunct),
    .a      (op_rn),
    .b      (op_b),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      p3_alu_aluOut    <= '0;
      p3_memAddr       <= '0;
      p3_mem_storeData <= '0;
      p3_alu_rd        <= '0;
      p3_mem_rd        <= '0;
      p3_alu_regWrite  <= 1'b0;
      p3_mem_regWrite  <= 1'b0;
      p3_memRead       <= 1'b0;
      p3_memWrite      <= 1'b0;
      p3_flag_regWrite <= 1'b0;
      flags_q          <= '0;
    end else if (p3_pipeline_regWrite) begin
      if (EX_stall || EX_flush) begin
        p3_alu_aluOut    <= '0;
        p3_memAddr       <= '0;
        p3_mem_storeData <= '0;
        p3_alu_rd        <= '0;
        p3_mem_rd        <= '0;
        p3_alu_regWrite  <= 1'b0;
        p3_mem_regWrite  <= 1'b0;
        p3_memRead       <= 1'b0;
        p3_memWrite      <= 1'b0;
        p3_flag_regWrite <= 1'b0;
      end else begin
        p3_alu_aluOut    <= alu_res;
        p3_memAddr       <= mem_rn + p2_memOffset;
        p3_mem_storeData <= mem_rd;
        p3_alu_rd        <= p2_alu_rd;
        p3_mem_rd        <= p2_mem_rd;
        p3_alu_regWrite  <= p2_alu_regWrite
                            && (p2_aluFunct != ALU_CMP);
        p3_mem_regWrite  <= p2_mem_regWrite;
        p3_memRead       <= p2_memRead;
        p3_memWrite      <= p2_memWrite;
        p3_flag_regWrite <= p2_flag_regWrite;
        if (p2_flag_regWrite)
          flags_q <= alu_flags;
      end
    end
  end

  assign p3_flag_z = flags_q.z;
  assign p3_flag_n = flags_q.n;
  assign p3_flag_c = flags_q.c;
  assign p3_flag_v = flags_q.v;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vector table plus forwarding,
// load-use stall, flush, hold and reset sequences.
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic        p3_pipeline_regWrite;
  logic        EX_flush;
  logic [2:0]  p2_alu_rm, p2_alu_rn, p2_alu_rd;
  logic [2:0]  p2_mem_rn, p2_mem_rd;
  logic [31:0] p2_alu_reg_rm, p2_alu_reg_rn;
  logic [31:0] p2_mem_reg_rn, p2_mem_reg_rd;
  logic [31:0] p2_alu_imm, p2_memOffset;
  logic [2:0]  p2_aluFunct;
  logic        p2_aluSrcB, p2_alu_regWrite, p2_flag_regWrite;
  logic        p2_memRead, p2_memWrite, p2_mem_regWrite;
  logic        p4_alu_regWrite, p4_mem_regWrite;
  logic [2:0]  p4_alu_rd, p4_mem_rd;
  logic [31:0] p4_alu_aluOut, p4_mem_memOut;
  logic [31:0] p3_alu_aluOut, p3_memAddr, p3_mem_storeData;
  logic [2:0]  p3_alu_rd, p3_mem_rd;
  logic        p3_alu_regWrite, p3_mem_regWrite;
  logic        p3_memRead, p3_memWrite, p3_flag_regWrite;
  logic        p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v;
  logic        EX_stall;

  int checks = 0;
  int failures = 0;

  ex_stage #(.DATA_W(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .p3_pipeline_regWrite (p3_pipeline_regWrite),
    .EX_flush             (EX_flush),
    .p2_alu_rm            (p2_alu_rm),
    .p2_alu_rn            (p2_alu_rn),
    .p2_alu_rd            (p2_alu_rd),
    .p2_mem_rn            (p2_mem_rn),
    .p2_mem_rd            (p2_mem_rd),
    .p2_alu_reg_rm        (p2_alu_reg_rm),
    .p2_alu_reg_rn        (p2_alu_reg_rn),
    .p2_mem_reg_rn        (p2_mem_reg_rn),
    .p2_mem_reg_rd        (p2_mem_reg_rd),
    .p2_alu_imm           (p2_alu_imm),
    .p2_memOffset         (p2_memOffset),
    .p2_aluFunct          (p2_aluFunct),
    .p2_aluSrcB           (p2_aluSrcB),
    .p2_alu_regWrite      (p2_alu_regWrite),
    .p2_flag_regWrite     (p2_flag_regWrite),
    .p2_memRead           (p2_memRead),
    .p2_memWrite          (p2_memWrite),
    .p2_mem_regWrite      (p2_mem_regWrite),
    .p4_alu_regWrite      (p4_alu_regWrite),
    .p4_mem_regWrite      (p4_mem_regWrite),
    .p4_alu_rd            (p4_alu_rd),
    .p4_mem_rd            (p4_mem_rd),
    .p4_alu_aluOut        (p4_alu_aluOut),
    .p4_mem_memOut        (p4_mem_memOut),
    .p3_alu_aluOut        (p3_alu_aluOut),
    .p3_memAddr           (p3_memAddr),
    .p3_mem_storeData     (p3_mem_storeData),
    .p3_alu_rd            (p3_alu_rd),
    .p3_mem_rd            (p3_mem_rd),
    .p3_alu_regWrite      (p3_alu_regWrite),
    .p3_mem_regWrite      (p3_mem_regWrite),
    .p3_memRead           (p3_memRead),
    .p3_memWrite          (p3_memWrite),
    .p3_flag_regWrite     (p3_flag_regWrite),
    .p3_flag_z            (p3_flag_z),
    .p3_flag_n            (p3_flag_n),
    .p3_flag_c            (p3_flag_c),
    .p3_flag_v            (p3_flag_v),
    .EX_stall             (EX_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2;
  localparam logic [2:0] OR  = 3'd3, XOR = 3'd4, SHL = 3'd5;
  localparam logic [2:0] SHR = 3'd6, CMP = 3'd7;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic        srcb;
    logic [31:0] imm;
    logic        fwe;
    logic [31:0] res;
    logic [3:0]  f;
    logic        we;
  } vec_t;

  localparam int NV = 15;
  vec_t v [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v};
  endfunction

  task automatic chk_zero(input string name);
    chk({name, "_data"},
        p3_alu_aluOut | p3_memAddr | p3_mem_storeData, 32'h0);
    chk({name, "_ctl"},
        {20'h0, p3_alu_rd, p3_mem_rd, p3_alu_regWrite,
         p3_mem_regWrite, p3_memRead, p3_memWrite,
         p3_flag_regWrite, EX_stall},
        32'h0);
    chk({name, "_flags"}, {28'h0, flags()}, 32'h0);
  endtask

  task automatic set_alu(input logic [2:0] fn,
                         input logic [2:0] rn,
                         input logic [31:0] rn_val,
                         input logic [31:0] imm,
                         input logic [2:0] rd,
                         input logic we,
                         input logic fwe);
    p2_aluFunct      = fn;
    p2_alu_rn        = rn;
    p2_alu_reg_rn    = rn_val;
    p2_alu_rm        = 3'd0;
    p2_alu_reg_rm    = 32'h0;
    p2_aluSrcB       = 1'b1;
    p2_alu_imm       = imm;
    p2_alu_rd        = rd;
    p2_alu_regWrite  = we;
    p2_flag_regWrite = fwe;
  endtask

  task automatic set_load();
    set_alu(ADD, 3'd0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    p2_memRead      = 1'b1;
    p2_mem_regWrite = 1'b1;
    p2_memWrite     = 1'b0;
    p2_mem_rd       = 3'd3;
    p2_mem_rn       = 3'd1;
    p2_mem_reg_rn   = 32'h100;
    p2_memOffset    = 32'h4;
  endtask

  task automatic set_use_r3();
    set_alu(ADD, 3'd3, 32'h9, 32'h1, 3'd4, 1'b1, 1'b0);
    p2_memRead      = 1'b0;
    p2_mem_regWrite = 1'b0;
    p2_mem_rn       = 3'd0;
    p2_mem_rd       = 3'd0;
    p2_mem_reg_rn   = 32'h0;
    p2_memOffset    = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    p3_pipeline_regWrite = 1'b1;
    EX_flush = 1'b0;
    p2_alu_rm = 3'd2; p2_alu_rn = 3'd1; p2_alu_rd = 3'd7;
    p2_mem_rn = 3'd5; p2_mem_rd = 3'd6;
    p2_alu_reg_rm = '0; p2_alu_reg_rn = '0;
    p2_mem_reg_rn = '0; p2_mem_reg_rd = '0;
    p2_alu_imm = '0; p2_memOffset = '0;
    p2_aluFunct = ADD; p2_aluSrcB = 1'b0;
    p2_alu_regWrite = 1'b0; p2_flag_regWrite = 1'b0;
    p2_memRead = 1'b0; p2_memWrite = 1'b0;
    p2_mem_regWrite = 1'b0;
    p4_alu_regWrite = 1'b0; p4_mem_regWrite = 1'b0;
    p4_alu_rd = 3'd0; p4_mem_rd = 3'd0;
    p4_alu_aluOut = '0; p4_mem_memOut = '0;

    // fn, a, b, srcb, imm, fwe, res, {z,n,c,v}, regWrite
    v[0]  = '{ADD, 32'h7FFF_FFFF, 32'h1, 0, 0, 1,
              32'h8000_0000, 4'b0101, 1};
    v[1]  = '{CMP, 32'h5, 32'h0, 1, 32'h5, 1,
              32'h0, 4'b1010, 0};
    v[2]  = '{SUB, 32'h3, 32'h5, 0, 0, 1,
              32'hFFFF_FFFE, 4'b0100, 1};
    v[3]  = '{SUB, 32'h8000_0000, 32'h1, 0, 0, 1,
              32'h7FFF_FFFF, 4'b0011, 1};
    v[4]  = '{ADD, 32'hFFFF_FFFF, 32'h1, 0, 0, 1,
              32'h0, 4'b1010, 1};
    v[5]  = '{AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 1,
              32'h00F0_00F0, 4'b0000, 1};
    v[6]  = '{OR, 32'h8000_0000, 32'h1, 0, 0, 1,
              32'h8000_0001, 4'b0100, 1};
    v[7]  = '{XOR, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0, 0, 1,
              32'h0, 4'b1000, 1};
    v[8]  = '{SHL, 32'h8000_0001, 32'h1, 0, 0, 1,
              32'h2, 4'b0010, 1};
    v[9]  = '{SHR, 32'h3, 32'h1, 0, 0, 1,
              32'h1, 4'b0010, 1};
    v[10] = '{SHL, 32'h1234, 32'h5, 1, 32'h20, 1,
              32'h1234, 4'b0000, 1};
    v[11] = '{SHR, 32'h8000_0000, 32'd31, 0, 0, 1,
              32'h1, 4'b0000, 1};
    v[12] = '{SHL, 32'h1, 32'd31, 0, 0, 1,
              32'h8000_0000, 4'b0100, 1};
    v[13] = '{AND, 32'hFFFF, 32'h0, 0, 0, 0,
              32'h0, 4'b0100, 1};
    v[14] = '{SUB, 32'h10, 32'h10, 0, 0, 1,
              32'h0, 4'b1010, 1};

    step();
    chk_zero("reset");
    reset = 1'b0;

    p2_alu_regWrite = 1'b1;
    for (int i = 0; i < NV; i++) begin
      p2_aluFunct      = v[i].fn;
      p2_alu_reg_rn    = v[i].a;
      p2_alu_reg_rm    = v[i].b;
      p2_aluSrcB       = v[i].srcb;
      p2_alu_imm       = v[i].imm;
      p2_flag_regWrite = v[i].fwe;
      p2_mem_reg_rn    = v[i].a;
      p2_memOffset     = v[i].b;
      p2_mem_reg_rd    = v[i].imm;
      step();
      chk($sformatf("v%0d_res", i), p3_alu_aluOut, v[i].res);
      chk($sformatf("v%0d_flags", i), {28'h0, flags()},
          {28'h0, v[i].f});
      chk($sformatf("v%0d_we", i), {31'h0, p3_alu_regWrite},
          {31'h0, v[i].we});
      chk($sformatf("v%0d_addr", i), p3_memAddr,
          v[i].a + v[i].b);
      chk($sformatf("v%0d_sd", i), p3_mem_storeData, v[i].imm);
    end

    // p3 vs p4 vs p4_mem forwarding priority on r2
    set_alu(ADD, 3'd1, 32'h2200, 32'h22, 3'd2, 1'b1, 1'b0);
    step();
    chk("fw_prod", p3_alu_aluOut, 32'h2222);
    p4_alu_regWrite = 1'b1; p4_alu_rd = 3'd2;
    p4_alu_aluOut = 32'h1111;
    p4_mem_regWrite = 1'b1; p4_mem_rd = 3'd2;
    p4_mem_memOut = 32'h3333;
    set_alu(ADD, 3'd2, 32'h5, 32'h0, 3'd7, 1'b1, 1'b0);
    step();
`ifdef EX_FORWARDING_EN
    chk("fw_p3", p3_alu_aluOut, 32'h2222);
`else
    chk("fw_p3", p3_alu_aluOut, 32'h5);
`endif
    step();
`ifdef EX_FORWARDING_EN
    chk("fw_p4alu", p3_alu_aluOut, 32'h1111);
`else
    chk("fw_p4alu", p3_alu_aluOut, 32'h5);
`endif
    p4_alu_regWrite = 1'b0;
    step();
`ifdef EX_FORWARDING_EN
    chk("fw_p4mem", p3_alu_aluOut, 32'h3333);
`else
    chk("fw_p4mem", p3_alu_aluOut, 32'h5);
`endif
    p4_mem_regWrite = 1'b0;
    step();
    chk("fw_none", p3_alu_aluOut, 32'h5);

    // load r3, then dependent ADD
    set_load();
    step();
    chk("ld_addr", p3_memAddr, 32'h104);
    chk("ld_ctl", {29'h0, p3_memRead, p3_mem_regWrite,
                   p3_alu_regWrite}, 32'h6);
    set_use_r3();
    #1;
`ifdef EX_FORWARDING_EN
    chk("lu_stall", {31'h0, EX_stall}, 32'h1);
    step();
    chk("lu_bubble", {p3_alu_aluOut[30:0], p3_alu_regWrite},
        32'h0);
    chk("lu_release", {31'h0, EX_stall}, 32'h0);
    p4_mem_regWrite = 1'b1; p4_mem_rd = 3'd3;
    p4_mem_memOut = 32'h40;
    step();
    chk("lu_result", p3_alu_aluOut, 32'h41);
`else
    chk("lu_stall", {31'h0, EX_stall}, 32'h0);
    step();
    chk("lu_stale", p3_alu_aluOut, 32'hA);
    step();
    chk("lu_result", p3_alu_aluOut, 32'hA);
`endif
    p4_mem_regWrite = 1'b0;

    // flush keeps flags, hold overrides everything
    set_alu(ADD, 3'd0, 32'hFFFF_FFFF, 32'h1, 3'd7, 1'b1, 1'b1);
    step();
    chk("fl_pre", {28'h0, flags()}, 32'hA);
    EX_flush = 1'b1;
    p2_memWrite = 1'b1;
    set_alu(SUB, 3'd0, 32'h1, 32'h2, 3'd7, 1'b1, 1'b1);
    step();
    chk("fl_ctl", {28'h0, p3_memWrite, p3_alu_regWrite,
                   p3_flag_regWrite, 1'b0}, 32'h0);
    chk("fl_data", p3_alu_aluOut, 32'h0);
    chk("fl_flags", {28'h0, flags()}, 32'hA);
    EX_flush = 1'b0;
    p3_pipeline_regWrite = 1'b0;
    set_alu(ADD, 3'd0, 32'h1, 32'h1, 3'd7, 1'b1, 1'b1);
    step();
    chk("hold_out", {p3_alu_aluOut[30:0], p3_memWrite}, 32'h0);
    chk("hold_flags", {28'h0, flags()}, 32'hA);
    p3_pipeline_regWrite = 1'b1;
    p2_memWrite = 1'b0;

    // reset in the middle of a stall with a flush pending
    set_load();
    step();
    set_use_r3();
    #1;
`ifdef EX_FORWARDING_EN
    chk("rs_stall", {31'h0, EX_stall}, 32'h1);
`else
    chk("rs_stall", {31'h0, EX_stall}, 32'h0);
`endif
    reset = 1'b1;
    EX_flush = 1'b1;
    step();
    chk_zero("rs_mid");
    reset = 1'b0;
    EX_flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
